// File: rtl/mantissa_multiplier.sv
// Sequential 24x24 shift-and-add mantissa multiplier with a valid/ready handshake on both sides.
// One multiplier bit per CALC cycle; zero operands bypass CALC straight to DONE.
module mantissa_multiplier (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] mant_a,
    input  logic [23:0] mant_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [47:0] mul_out,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e      state_q, state_d;
    logic [47:0] mcand_q, mcand_d;
    logic [47:0] prod_q, prod_d;
    logic [23:0] mplier_q, mplier_d;
    logic [4:0]  cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            mcand_q  <= '0;
            prod_q   <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    mcand_d  = {24'd0, mant_a};
                    mplier_d = mant_b;
                    prod_d   = '0;
                    cnt_d    = '0;
                    state_d  = (mant_a == '0 || mant_b == '0) ? StDone : StCalc;
                end
            end
            StCalc: begin
                if (mplier_q[0]) begin
                    prod_d = prod_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 5'd1;
                // Counter ends at 24 after the last step, so it never wraps.
                if (cnt_q == 5'd23) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == StIdle);
        busy      = (state_q == StCalc);
        out_valid = (state_q == StDone);
        mul_out   = prod_q;
    end

endmodule

// File: tb/tb_mantissa_multiplier.sv
// Self-checking bench for mantissa_multiplier: directed vectors plus randomized operands
// compared against an arithmetic product model.
module tb_mantissa_multiplier;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] mant_a;
    logic [23:0] mant_b;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] mul_out;
    logic        busy;

    int checks;
    int failures;

    mantissa_multiplier dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mant_a   (mant_a),
        .mant_b   (mant_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .mul_out  (mul_out),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [47:0] model_product(input logic [23:0] a, input logic [23:0] b);
        longint unsigned p;
        p = longint'(a) * longint'(b);
        return p[47:0];
    endfunction

    // Edges from the accept edge (inclusive) until out_valid is seen: 1 for a zero operand,
    // 25 (accept + 24 CALC edges) otherwise.
    function automatic int model_latency(input logic [23:0] a, input logic [23:0] b);
        return (a == 24'd0 || b == 24'd0) ? 1 : 25;
    endfunction

    // Issue one operand pair from IDLE (called at posedge+1) and run until out_valid or timeout.
    task automatic do_op(input logic [23:0] a, input logic [23:0] b, input bit hold_valid,
                         output int lat, output int busy_cnt);
        mant_a    = a;
        mant_b    = b;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        lat       = 0;
        busy_cnt  = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) busy_cnt++;
            if (hold_valid) begin
                mant_a = 24'($urandom);
                mant_b = 24'($urandom);
            end else begin
                in_valid = 1'b0;
            end
        end while (!out_valid && lat < 40);
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        mant_a    = '0;
        mant_b    = '0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || mul_out !== 48'd0) begin
            failures++;
            $display("FAIL reset_values: in_ready=%b out_valid=%b busy=%b mul_out=%h, want 1 0 0 0",
                     in_ready, out_valid, busy, mul_out);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
                failures++;
                $display("FAIL reset_release_quiet: out_valid=%b in_ready=%b busy=%b, want 0 1 0",
                         out_valid, in_ready, busy);
            end
        end
    endtask

    task automatic test_directed();
        logic [23:0] va [3];
        logic [47:0] vp [3];
        int lat, bc;
        va[0] = 24'h800000; vp[0] = 48'h400000000000;
        va[1] = 24'hC00000; vp[1] = 48'h900000000000;
        va[2] = 24'hFFFFFF; vp[2] = 48'hFFFFFE000001;
        for (int i = 0; i < 3; i++) begin
            do_op(va[i], va[i], (i == 2), lat, bc);
            checks++;
            if (lat !== 25 || mul_out !== vp[i] || vp[i] !== model_product(va[i], va[i])) begin
                failures++;
                $display("FAIL directed_%0d: lat=%0d mul_out=%h, want lat=25 mul_out=%h",
                         i, lat, mul_out, vp[i]);
            end
            checks++;
            if (bc !== 24 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL directed_busy_%0d: busy_cycles=%0d in_ready=%b, want 24 0",
                         i, bc, in_ready);
            end
            handoff();
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL directed_handoff_%0d: in_ready=%b out_valid=%b, want 1 0",
                         i, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_zero();
        int lat, bc;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) do_op(24'h000000, 24'h800000, 1'b0, lat, bc);
            else        do_op(24'hABCDEF, 24'h000000, 1'b0, lat, bc);
            checks++;
            if (lat !== 1 || bc !== 0 || mul_out !== 48'd0 || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL zero_%0d: lat=%0d busy_cycles=%0d mul_out=%h, want 1 0 0",
                         i, lat, bc, mul_out);
            end
            handoff();
        end
    endtask

    task automatic test_backpressure();
        int lat, bc;
        do_op(24'h800000, 24'hC00000, 1'b0, lat, bc);
        checks++;
        if (lat !== 25 || mul_out !== 48'h600000000000) begin
            failures++;
            $display("FAIL bp_result: lat=%0d mul_out=%h, want 25 600000000000", lat, mul_out);
        end
        in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            checks++;
            if (mul_out !== 48'h600000000000 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL bp_hold: mul_out=%h in_ready=%b out_valid=%b, want 600000000000 0 1",
                         mul_out, in_ready, out_valid);
            end
        end
        handoff();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        mant_a   = 24'h800000;
        mant_b   = 24'hC00000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (mul_out !== 48'd0 || busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: mul_out=%h busy=%b in_ready=%b out_valid=%b, want 0 0 1 0",
                     mul_out, busy, in_ready, out_valid);
        end
        @(posedge clk);
        #3;
        mant_a   = 24'h800000;
        mant_b   = 24'h800000;
        in_valid = 1'b1;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_first_accept: busy=%b, want 1", busy);
        end
        n = 1;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n !== 25 || mul_out !== 48'h400000000000) begin
            failures++;
            $display("FAIL reset_recover: lat=%0d mul_out=%h, want 25 400000000000", n, mul_out);
        end
        handoff();
    endtask

    task automatic test_random();
        logic [23:0] a, b;
        int lat, bc, wait_cycles;
        for (int i = 0; i < 24; i++) begin
            a = 24'($urandom);
            b = 24'($urandom);
            if (i % 8 == 3) a = 24'd0;
            if (i % 8 == 5) b = 24'd1;
            if (i % 8 == 6) a = 24'd1;
            do_op(a, b, ($urandom_range(0, 1) == 1), lat, bc);
            checks++;
            if (lat !== model_latency(a, b) || mul_out !== model_product(a, b)) begin
                failures++;
                $display("FAIL random_%0d: a=%h b=%h lat=%0d mul_out=%h, want lat=%0d mul_out=%h",
                         i, a, b, lat, mul_out, model_latency(a, b), model_product(a, b));
            end
            wait_cycles = $urandom_range(0, 3);
            repeat (wait_cycles) @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || mul_out !== model_product(a, b)) begin
                failures++;
                $display("FAIL random_hold_%0d: out_valid=%b mul_out=%h, want 1 %h",
                         i, out_valid, mul_out, model_product(a, b));
            end
            handoff();
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_directed();
        test_zero();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
